// File: rtl/vector_alu_pkg.sv
// Shared types and width-derived saturation constants for the vector add/sub ALU.
package vector_alu_pkg;

  localparam int LANE_W = 8;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    logic sub;
    logic sat;
    logic sgn;
  } alu_op_t;

  function automatic logic [63:0] umax_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] smax_of(input int w);
    return umax_of(w - 1);
  endfunction

  function automatic logic [63:0] smin_of(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/lane_addsub_sat.sv
// Single-lane add/sub with wrap or signed/unsigned saturation and C/V/N/Z flags.
// Purely combinational; no handshake, the enclosing pipeline owns timing.
module lane_addsub_sat
  import vector_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_t      op,
  input  logic         en,
  output logic [W-1:0] res,
  output logic         c,
  output logic         v,
  output logic         n,
  output logic         z
);

  localparam logic [63:0] SMAX64 = smax_of(W);
  localparam logic [63:0] SMIN64 = smin_of(W);
  localparam logic [63:0] UMAX64 = umax_of(W);
  localparam logic [W-1:0] SMAX = SMAX64[W-1:0];
  localparam logic [W-1:0] SMIN = SMIN64[W-1:0];
  localparam logic [W-1:0] UMAX = UMAX64[W-1:0];

  logic [W-1:0] b_eff;
  logic [W-1:0] sat_val;
  logic [W:0]   raw;
  logic         carry;
  logic         ovf;
  logic         clamp;

  always_comb begin
    b_eff   = op.sub ? ~b : b;
    raw     = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, op.sub};
    carry   = raw[W];
    ovf     = (a[W-1] == b_eff[W-1]) && (raw[W-1] != a[W-1]);
    clamp   = 1'b0;
    sat_val = raw[W-1:0];
    if (op.sat) begin
      if (op.sgn) begin
        clamp   = ovf;
        sat_val = a[W-1] ? SMIN : SMAX;
      end else if (op.sub) begin
        // unsigned subtract: carry-out low means a borrow occurred
        clamp   = !carry;
        sat_val = '0;
      end else begin
        clamp   = carry;
        sat_val = UMAX;
      end
    end
    res = clamp ? sat_val : raw[W-1:0];
    c   = carry;
    v   = ovf;
    n   = res[W-1];
    z   = (res == '0);
    if (!en) begin
      res = a;
      c   = 1'b0;
      v   = 1'b0;
      n   = 1'b0;
      z   = 1'b0;
    end
  end

endmodule

// File: rtl/vector_addsub_pipe.sv
// Two-stage SIMD add/sub: stage 1 captures operands, stage 2 registers lane results/flags.
// Latency 2; valid/ready with per-stage skid so in_ready drops only when both stages hold data.
module vector_addsub_pipe
  import vector_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]     operand1,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]     operand2,
  input  logic                                 op_sub,
  input  logic                                 op_sat,
  input  logic                                 op_signed,
  input  logic [LANES-1:0]                     lane_en,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES-1:0][DATA_WIDTH-1:0]     result,
  output logic [LANES-1:0]                     C,
  output logic [LANES-1:0]                     V,
  output logic [LANES-1:0]                     N,
  output logic [LANES-1:0]                     Z
);

  logic                             s1_valid;
  logic                             s2_valid;
  logic                             s1_ready;
  logic                             s2_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0] s1_a;
  logic [LANES-1:0][DATA_WIDTH-1:0] s1_b;
  alu_op_t                          s1_op;
  logic [LANES-1:0]                 s1_en;
  logic [LANES-1:0][DATA_WIDTH-1:0] lane_res;
  logic [LANES-1:0]                 lane_c;
  logic [LANES-1:0]                 lane_v;
  logic [LANES-1:0]                 lane_n;
  logic [LANES-1:0]                 lane_z;

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_en    <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= operand1;
        s1_b  <= operand2;
        s1_op <= '{sub: op_sub, sat: op_sat, sgn: op_signed};
        s1_en <= lane_en;
      end
    end
  end

  // Outputs only change when stage 2 advances, so a stalled result is held bit-exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      result   <= '0;
      C        <= '0;
      V        <= '0;
      N        <= '0;
      Z        <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result <= lane_res;
        C      <= lane_c;
        V      <= lane_v;
        N      <= lane_n;
        Z      <= lane_z;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_addsub_sat #(
      .W (DATA_WIDTH)
    ) u_lane (
      .a   (s1_a[i]),
      .b   (s1_b[i]),
      .op  (s1_op),
      .en  (s1_en[i]),
      .res (lane_res[i]),
      .c   (lane_c[i]),
      .v   (lane_v[i]),
      .n   (lane_n[i]),
      .z   (lane_z[i])
    );
  end

endmodule

// File: tb/tb_vector_addsub_pipe.sv
// Bench for vector_addsub_pipe: an 8x8 and a 4x16 instance checked against an integer-arithmetic model.
module tb_vector_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv0, ir0, ov0, or0, sub0, sat0, sgn0;
  logic [63:0] a0, b0, r0;
  logic [7:0]  en0, c0, v0, n0, z0;

  logic        iv1, ir1, ov1, or1, sub1, sat1, sgn1;
  logic [63:0] a1, b1, r1;
  logic [3:0]  en1, c1, v1, n1, z1;

  vector_addsub_pipe #(.DATA_WIDTH(8), .LANES(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .operand1(a0), .operand2(b0), .op_sub(sub0), .op_sat(sat0), .op_signed(sgn0),
    .lane_en(en0), .out_valid(ov0), .out_ready(or0), .result(r0),
    .C(c0), .V(v0), .N(n0), .Z(z0)
  );

  vector_addsub_pipe #(.DATA_WIDTH(16), .LANES(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .operand1(a1), .operand2(b1), .op_sub(sub1), .op_sat(sat1), .op_signed(sgn1),
    .lane_en(en1), .out_valid(ov1), .out_ready(or1), .result(r1),
    .C(c1), .V(v1), .N(n1), .Z(z1)
  );

  typedef struct {
    logic [63:0] res;
    logic [7:0]  c, v, n, z;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        q0[$], q1[$];
  exp_t        cur0, cur1;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  bit          lat_on = 0, post = 0, acc0 = 0, acc1 = 0;
  bit          stall[2];
  logic [63:0] hres[2];
  logic [31:0] hflg[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sums, then wrap or clamp into the lane's range.
  function automatic exp_t build(input int w, input int lanes, input logic [63:0] a, input logic [63:0] b,
                                 input bit sub, input bit sat, input bit sgn, input logic [7:0] en);
    exp_t   e;
    longint m, ua, ub, full, sa, sb, se, r;
    e.res = '0; e.c = '0; e.v = '0; e.n = '0; e.z = '0; e.acc = 0; e.lat = 0;
    m = longint'(1) << w;
    for (int i = 0; i < lanes; i++) begin
      ua   = longint'((a >> (i * w)) & 64'(m - 1));
      ub   = longint'((b >> (i * w)) & 64'(m - 1));
      full = sub ? ua - ub : ua + ub;
      sa   = (ua >= m / 2) ? ua - m : ua;
      sb   = (ub >= m / 2) ? ub - m : ub;
      se   = sub ? sa - sb : sa + sb;
      if (!en[i]) begin
        r = ua;
      end else begin
        e.c[i] = sub ? (ua >= ub) : (full >= m);
        e.v[i] = (se > m / 2 - 1) || (se < -(m / 2));
        if (sat && sgn) begin
          if (se > m / 2 - 1) se = m / 2 - 1;
          if (se < -(m / 2)) se = -(m / 2);
          r = (se < 0) ? se + m : se;
        end else if (sat) begin
          r = (full < 0) ? 0 : (full > m - 1) ? m - 1 : full;
        end else begin
          r = ((full % m) + m) % m;
        end
        e.n[i] = (r >= m / 2);
        e.z[i] = (r == 0);
      end
      e.res |= 64'(r) << (i * w);
    end
    return e;
  endfunction

  function automatic logic [15:0] pick(input int w);
    logic [15:0] x;
    x = 16'($urandom);
    case ($urandom_range(0, 5))
      0: x = 16'd0;
      1: x = 16'd1;
      2: x = 16'((1 << (w - 1)) - 1);
      3: x = 16'(1 << (w - 1));
      4: x = 16'((1 << w) - 1);
      default: ;
    endcase
    return x & 16'((1 << w) - 1);
  endfunction

  task automatic drive0(input logic [63:0] a, input logic [63:0] b, input bit sub, input bit sat,
                        input bit sgn, input logic [7:0] en);
    a0 = a; b0 = b; sub0 = sub; sat0 = sat; sgn0 = sgn; en0 = en; iv0 = 1'b1;
    cur0 = build(8, 8, a, b, sub, sat, sgn, en);
  endtask

  task automatic drive1(input logic [63:0] a, input logic [63:0] b, input bit sub, input bit sat,
                        input bit sgn, input logic [3:0] en);
    a1 = a; b1 = b; sub1 = sub; sat1 = sat; sgn1 = sgn; en1 = en; iv1 = 1'b1;
    cur1 = build(16, 4, a, b, sub, sat, sgn, {4'b0, en});
  endtask

  task automatic rand0();
    logic [63:0] a, b;
    a = '0; b = '0;
    for (int i = 0; i < 8; i++) begin
      a |= 64'(pick(8)) << (8 * i);
      b |= 64'(pick(8)) << (8 * i);
    end
    drive0(a, b, 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF);
  endtask

  task automatic rand1();
    logic [63:0] a, b;
    a = '0; b = '0;
    for (int i = 0; i < 4; i++) begin
      a |= 64'(pick(16)) << (16 * i);
      b |= 64'(pick(16)) << (16 * i);
    end
    drive1(a, b, 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF);
  endtask

  task automatic mon(input int d, input logic ov, input logic ordy, input logic ir,
                     input logic [63:0] r, input logic [7:0] c, input logic [7:0] v,
                     input logic [7:0] n, input logic [7:0] z);
    exp_t        e;
    int          occ;
    logic [31:0] flg;
    flg = {c, v, n, z};
    occ = (d == 0) ? q0.size() : q1.size();
    check($sformatf("in_ready%0d", d), ir, !(occ == 2 && !ordy));
    if (ov && occ == 0) check($sformatf("spurious_out%0d", d), ov, 0);
    if (stall[d]) begin
      check($sformatf("stall_valid%0d", d), ov, 1);
      check($sformatf("stall_result%0d", d), r, hres[d]);
      check($sformatf("stall_flags%0d", d), flg, hflg[d]);
    end
    if (ov && ordy && occ > 0) begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check($sformatf("result%0d", d), r, e.res);
      check($sformatf("flags_cvnz%0d", d), flg, {e.c, e.v, e.n, e.z});
      if (e.lat) check($sformatf("latency%0d", d), 64'(cyc - e.acc), 2);
    end
    stall[d] = ov && !ordy;
    hres[d]  = r;
    hflg[d]  = flg;
  endtask

  // One cycle: observe at the falling edge, then return just after the rising edge for driving.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rst) begin
      q0.delete();
      q1.delete();
      stall = '{0, 0};
      post  = 1;
      acc0  = 0;
      acc1  = 0;
    end else begin
      if (post) begin
        check("rst_out_valid0", ov0, 0);
        check("rst_in_ready0", ir0, 1);
        check("rst_result0", r0, 0);
        check("rst_flags0", {c0, v0, n0, z0}, 0);
        check("rst_out_valid1", ov1, 0);
        check("rst_in_ready1", ir1, 1);
        check("rst_result1", r1, 0);
        check("rst_flags1", {c1, v1, n1, z1}, 0);
        post = 0;
      end
      mon(0, ov0, or0, ir0, r0, c0, v0, n0, z0);
      mon(1, ov1, or1, ir1, r1, {4'b0, c1}, {4'b0, v1}, {4'b0, n1}, {4'b0, z1});
      acc0 = iv0 && ir0;
      acc1 = iv1 && ir1;
      if (acc0) begin cur0.acc = cyc; cur0.lat = lat_on; q0.push_back(cur0); end
      if (acc1) begin cur1.acc = cyc; cur1.lat = lat_on; q1.push_back(cur1); end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, t;
    rst = 1'b1;
    iv0 = 0; or0 = 1; a0 = '0; b0 = '0; sub0 = 0; sat0 = 0; sgn0 = 0; en0 = '0;
    iv1 = 0; or1 = 1; a1 = '0; b1 = '0; sub1 = 0; sat1 = 0; sgn1 = 0; en1 = '0;
    stall = '{0, 0};
    repeat (2) step();
    rst = 1'b0;

    // Directed corner cases, streamed back to back with the consumer always ready.
    lat_on = 1;
    drive0({8{8'h7F}}, {8{8'h01}}, 0, 0, 0, 8'hFF);
    drive1({4{16'h7FFF}}, {4{16'h0001}}, 0, 1, 1, 4'hF);
    step();
    drive0({8{8'h7F}}, {8{8'h01}}, 0, 1, 1, 8'hFF);
    drive1({4{16'h8000}}, {4{16'h0001}}, 1, 1, 1, 4'hF);
    step();
    drive0({8{8'h80}}, {8{8'h01}}, 1, 1, 1, 8'hFF);
    drive1({4{16'hFFF0}}, {4{16'h0020}}, 0, 1, 0, 4'hF);
    step();
    iv1 = 0;
    drive0({8{8'hF0}}, {8{8'h20}}, 0, 1, 0, 8'hFF);
    step();
    drive0({8{8'h10}}, {8{8'h20}}, 1, 1, 0, 8'hFF);
    step();
    drive0({8{8'h11}}, {8{8'h22}}, 0, 0, 0, 8'hAA);
    step();
    iv0 = 0;
    repeat (4) step();
    lat_on = 0;

    // Six bundles with the consumer stalled for four cycles mid-stream.
    sent = 0;
    t    = 0;
    rand0();
    while (sent < 6 && t < 40) begin
      or0 = !(t >= 2 && t < 6);
      step();
      t++;
      if (acc0) begin
        sent++;
        if (sent < 6) rand0();
        else iv0 = 0;
      end
    end
    iv0 = 0;
    or0 = 1;
    check("bp_sent", 64'(sent), 6);
    repeat (4) step();
    check("bp_drained", 64'(q0.size()), 0);

    // Two bundles in flight in each instance, then a one-cycle reset.
    or0 = 0; or1 = 0;
    rand0(); rand1();
    step();
    rand0(); rand1();
    step();
    iv0 = 0; iv1 = 0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    or0 = 1; or1 = 1;
    repeat (5) step();

    // Random traffic with random back-pressure on both instances.
    rand0();
    rand1();
    for (int k = 0; k < 400; k++) begin
      or0 = ($urandom_range(0, 3) != 0);
      or1 = ($urandom_range(0, 3) != 0);
      step();
      if (acc0 || !iv0) begin
        if ($urandom_range(0, 3) != 0) rand0();
        else iv0 = 0;
      end
      if (acc1 || !iv1) begin
        if ($urandom_range(0, 3) != 0) rand1();
        else iv1 = 0;
      end
    end
    iv0 = 0; iv1 = 0;
    or0 = 1; or1 = 1;
    repeat (5) step();
    check("final_drain0", 64'(q0.size()), 0);
    check("final_drain1", 64'(q1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_addsub_pipe.md
Name: vector_addsub_pipe

Overview:
Parametrised, pipelined SIMD adder/subtractor for the vector ALU in the Execute stage. Operates on LANES independent lanes of DATA_WIDTH bits. Supports wrap, signed-saturating and unsigned-saturating add/sub, plus a per-lane write mask. Produces per-lane C/V/N/Z flags behind a two-stage valid/ready pipeline that stalls cleanly under downstream back-pressure.

Parameters:
DATA_WIDTH, 8, bits per lane (>=2)
LANES, 8, number of lanes (>=1); all lane logic is generate-instantiated

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept a bundle this cycle
operand1  input  LANES x DATA_WIDTH  packed lane vector A, lane i at [i]
operand2  input  LANES x DATA_WIDTH  packed lane vector B
op_sub  input  1  0 = A+B, 1 = A-B
op_sat  input  1  1 = saturate, 0 = wrap
op_signed  input  1  saturation domain: 1 = two's complement, 0 = unsigned; ignored when op_sat=0
lane_en  input  LANES  per-lane enable mask
out_valid  output  1  result bundle valid
out_ready  input  1  consumer accepts result
result  output  LANES x DATA_WIDTH  per-lane result
C, V, N, Z  output  LANES each  per-lane carry, overflow, negative, zero flags

Behaviour:
- Reset: s1_valid=0, s2_valid=0, so out_valid=0 and in_ready=1 in the cycle after rst. result and flags reset to 0. rst mid-operation discards all in-flight bundles; no partial output.
- Handshake: a transfer occurs when valid&&ready on the same edge. s2_ready = !s2_valid || out_ready. s1_ready = !s1_valid || s2_ready. in_ready = s1_ready. The combinational out_ready->in_ready path is permitted.
- Stage 1: on an accepted input, register operands, op_*, and lane_en. No arithmetic.
- Stage 2: on advance, compute all lanes from the s1 registers and register result and flags.
- Latency: 2 cycles from input acceptance to out_valid. Throughput: 1 bundle/cycle when out_ready=1.
- Stall: while out_valid && !out_ready, result and flags hold stable and bit-identical. Stage 1 may still fill one bundle; in_ready drops only when both stages are full.
- Simultaneous accept and drain in a full pipe: both stages advance on the same edge, with no bubble and no loss.
- Per-lane arithmetic (one DATA_WIDTH+1-bit add):
  - raw = A + (op_sub ? ~B : B) + op_sub.
  - C = carry-out. For sub, C=1 means no borrow (A>=B unsigned).
  - V = signed overflow: (A[msb]==B'[msb]) && (raw[msb]!=A[msb]), where B' is the effective second operand.
- Saturation with op_sat=1:
  - Signed: when V=1, clamp to the max positive value if A[msb]=0, else to the min negative value.
  - Unsigned add: clamp to all-ones when C=1.
  - Unsigned sub: clamp to 0 when C=0.
  - Otherwise the raw sum is used. With op_sat=0 the result is always the raw sum.
- Flag semantics: C and V always describe the raw operation, even when saturated. N = final result msb. Z = (final result == 0).
- Masked lane (lane_en[i]=0): result[i]=operand1[i]; C/V/N/Z[i]=0.
- Lanes are fully independent; no carry crosses lanes.

Decomposition:
- Package vector_alu_pkg holds:
  - lane_t: logic [DATA_WIDTH-1:0], parameterised via localparam default 8.
  - alu_op_t: struct {sub, sat, sgn}.
  - Constants for signed max/min and unsigned max, expressed as functions of width.
- One sub-module, lane_addsub_sat: combinational single-lane add/sub, saturation and flags. The top instantiates it LANES times in a generate loop and owns the pipeline and handshake.

Test Plan:
- Wrap add, DATA_WIDTH=8: A=0x7F, B=0x01, op_sub=0, op_sat=0 -> result 0x80, C=0, V=1, N=1, Z=0, out_valid exactly 2 cycles after accept.
- Signed sat: A=0x7F+0x01 -> 0x7F with V=1. A=0x80-0x01 (sub) -> 0x80 with V=1, C=1. Check N/Z from the clamped value.
- Unsigned sat: add 0xF0+0x20 -> 0xFF with C=1. Sub 0x10-0x20 -> 0x00 with C=0 and Z=1.
- Mask: lane_en=8'b1010_1010, A lanes=0x11, B lanes=0x22, add -> odd lanes 0x33, even lanes 0x11 with all flags 0.
- Back-pressure: stream 6 bundles with out_ready low for 4 cycles mid-stream -> in_ready drops after 2 bundles pending; output stays stable while stalled; all 6 results emerge in order with no duplication or loss.
- Reset mid-flight, with 2 bundles in the pipe: rst high 1 cycle -> next cycle out_valid=0, in_ready=1, and none of the flushed bundles ever appears. Repeat with LANES=4, DATA_WIDTH=16: 0x7FFF+1 signed sat -> 0x7FFF.
